// File: rtl/sram_pkg.sv
// sram_pkg: shared FSM states and default parameters for the 16-bit SRAM word controller
package sram_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;
  localparam int BASE_ADDR_DEF = 1024;
  localparam int SRAM_AW_DEF = 18;
endpackage

// File: rtl/sram_controller.sv
// sram_controller: services 32-bit MEM-stage reads/writes as two half-word accesses on async SRAM; ready low freezes core
module sram_controller
  import sram_pkg::*;
#(
  parameter int BASE_ADDR = BASE_ADDR_DEF,
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW = SRAM_AW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);
  localparam int CW = (WAIT_CYCLES < 4) ? 2 : $clog2(WAIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic op_wr;
  logic [SRAM_AW-2:0] idx;
  logic [31:0] wdata;
  logic [15:0] low_half;
  logic [31:0] offset;
  logic req, last, active, drive;
  logic unused_offset;
  assign req = rd_en | wr_en;
  assign offset = address - 32'(BASE_ADDR);
  assign unused_offset = ^{offset[31:SRAM_AW+1], offset[1:0]};
  assign last = cnt == LAST;
  assign active = state == LOW || state == HIGH;
  assign drive = op_wr && active;
  assign ready = ~req | (state == DONE);
  assign SRAM_DQ = drive ? (state == HIGH ? wdata[31:16] : wdata[15:0]) : 16'bz;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  always_comb begin
    state_n = state;
    cnt_n = '0;
    SRAM_WE_N = ~drive;
    SRAM_OE_N = drive;
    SRAM_ADDR = active ? {idx, state == HIGH} : '0;
    case (state)
      IDLE: state_n = req ? LOW : IDLE;
      LOW: begin
        state_n = last ? HIGH : LOW;
        cnt_n = last ? '0 : cnt + CW'(1);
      end
      HIGH: begin
        state_n = last ? DONE : HIGH;
        cnt_n = last ? '0 : cnt + CW'(1);
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      op_wr <= 1'b0;
      idx <= '0;
      wdata <= '0;
      low_half <= '0;
      read_data <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (state == IDLE && req) begin
        op_wr <= wr_en;
        idx <= offset[SRAM_AW:2];
        wdata <= write_data;
      end
      if (state == LOW && last && !op_wr) low_half <= SRAM_DQ;
      if (state == HIGH && last && !op_wr) read_data <= {SRAM_DQ, low_half};
    end
  end
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: randomized scoreboard bench for sram_controller with a behavioural async SRAM
module tb_sram_controller;
  localparam int W = 2;
  typedef struct {
    bit wr;
    int idx;
    logic [31:0] data;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  logic rd_en = 0, wr_en = 0;
  logic [31:0] address = 0, write_data = 0;
  logic [31:0] read_data;
  logic ready;
  wire [15:0] dq;
  logic [17:0] sram_addr;
  logic we_n, oe_n, ce_n, ub_n, lb_n;
  logic [15:0] mem [0:262143];
  logic [31:0] ref_w [int];
  exp_t q[$];
  exp_t mon_e;
  int checks = 0, failures = 0;
  int k = 0;
  bit in_reset = 0;
  bit h;
  logic [31:0] last_rd = 0;
  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(W), .SRAM_AW(18)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .SRAM_DQ(dq),
    .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );
  always #5 clk = ~clk;
  assign dq = (!oe_n && we_n) ? mem[sram_addr] : 16'bz;
  always @(posedge clk) if (!we_n) mem[sram_addr] = dq;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] ref_rd(input int i);
    return ref_w.exists(i) ? ref_w[i] : 32'h0;
  endfunction
  function automatic logic [17:0] ha(input int i, input bit hi);
    return 18'(i * 2 + int'(hi));
  endfunction
  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return int'((off >> 2) & 32'h1FFFF);
  endfunction
  task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int n;
    e.wr = wr;
    e.idx = widx(a);
    e.data = wr ? d : ref_rd(e.idx);
    if (wr) ref_w[e.idx] = d;
    q.push_back(e);
    rd_en = rd;
    wr_en = wr;
    address = a;
    write_data = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 50);
    if (!ready) chk("access_timeout", n, 2 * W + 1);
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    rd_en = 0;
    wr_en = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  always @(negedge clk) begin
    if (rst || in_reset) k = 0;
    else if ((rd_en || wr_en) && q.size() > 0) begin
      mon_e = q[0];
      if (!ready) begin
        if (k == 0 || k > 2 * W) begin
          chk("addr_edge", 32'(sram_addr), 0);
          chk("we_edge", 32'(we_n), 1);
        end else begin
          h = k > W;
          chk("addr_phase", 32'(sram_addr), 32'(ha(mon_e.idx, h)));
          chk("we_phase", 32'(we_n), 32'(!mon_e.wr));
          chk("oe_phase", 32'(oe_n), 32'(mon_e.wr));
          chk("dq_phase", 32'(dq), mon_e.wr ? 32'(h ? mon_e.data[31:16] : mon_e.data[15:0]) : 32'(mem[sram_addr]));
        end
        k++;
      end else begin
        chk("latency", k, 2 * W + 1);
        chk("addr_done", 32'(sram_addr), 0);
        chk("we_done", 32'(we_n), 1);
        if (mon_e.wr) begin
          chk("mem_lo", 32'(mem[ha(mon_e.idx, 0)]), 32'(mon_e.data[15:0]));
          chk("mem_hi", 32'(mem[ha(mon_e.idx, 1)]), 32'(mon_e.data[31:16]));
        end else begin
          chk("read_data", read_data, mon_e.data);
          last_rd = mon_e.data;
        end
        chk("queue_depth", q.size(), 1);
        void'(q.pop_front());
        k = 0;
      end
    end else if (!(rd_en || wr_en)) begin
      chk("idle_ready", 32'(ready), 1);
      chk("idle_we", 32'(we_n), 1);
      chk("idle_oe", 32'(oe_n), 0);
      chk("idle_addr", 32'(sram_addr), 0);
      chk("tied_pins", 32'({ce_n, ub_n, lb_n}), 0);
    end
    if (!rst && !in_reset) chk("read_hold", read_data, last_rd);
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [31:0] a, d, old;
    int i;
    for (int j = 0; j < 262144; j++) mem[j] = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_read_data", read_data, 0);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_we", 32'(we_n), 1);
    @(posedge clk);
    #1;
    rst = 0;
    idle(4);
    issue(0, 1, 32'd1024, 32'hDEADBEEF);
    chk("plan_mem0", 32'(mem[0]), 32'hBEEF);
    chk("plan_mem1", 32'(mem[1]), 32'hDEAD);
    issue(1, 0, 32'd1024, 32'h0);
    issue(0, 1, 32'd1032, 32'h12345678);
    chk("plan_mem4", 32'(mem[4]), 32'h5678);
    chk("plan_mem5", 32'(mem[5]), 32'h1234);
    issue(1, 0, 32'd1032, 32'h0);
    idle(2);
    issue(1, 0, 32'd1024, 32'h0);
    issue(1, 0, 32'd1032, 32'h0);
    idle(3);
    in_reset = 1;
    old = ref_rd(4);
    wr_en = 1;
    address = 32'd1040;
    write_data = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    wr_en = 0;
    @(negedge clk);
    chk("reset_we", 32'(we_n), 1);
    chk("reset_addr", 32'(sram_addr), 0);
    chk("reset_read_data", read_data, 0);
    chk("reset_ready", 32'(ready), 1);
    chk("reset_partial_lo", 32'(mem[8]), 32'hF00D);
    chk("reset_partial_hi", 32'(mem[9]), 32'(old[31:16]));
    ref_w[4] = {old[31:16], 16'hF00D};
    @(posedge clk);
    #1;
    rst = 0;
    last_rd = 0;
    in_reset = 0;
    idle(2);
    issue(1, 0, 32'd1040, 32'h0);
    issue(1, 1, 32'd1048, 32'hA5A5A5A5);
    chk("dual_mem12", 32'(mem[12]), 32'hA5A5);
    chk("dual_mem13", 32'(mem[13]), 32'hA5A5);
    issue(1, 0, 32'd1050, 32'h0);
    issue(0, 1, 32'd1024 + ((32'h20000 + 32'd7) << 2), 32'h0BADF00D);
    issue(1, 0, 32'd1024 + 32'd28, 32'h0);
    for (int n = 0; n < 200; n++) begin
      i = $urandom_range(0, 31);
      a = 32'd1024 + 32'(i) * 4 + 32'($urandom_range(0, 3));
      d = $urandom;
      case ($urandom_range(0, 4))
        0, 1: issue(0, 1, a, d);
        2, 3: issue(1, 0, a, d);
        default: issue(1, 1, a, d);
      endcase
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
